// File: rtl/clock_pkg.sv
//======================================================================
// Module      : clock_pkg
// Description : Shared types, constants and load-validation helper for
//               the multi-alarm clock.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic [1:0] hour1;
        bcd_t       hour0;
        bcd_t       min1;
        bcd_t       min0;
    } hhmm_t;

    typedef struct packed {
        logic [1:0] hour1;
        bcd_t       hour0;
        bcd_t       min1;
        bcd_t       min0;
        logic       en;
    } alarm_slot_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int MAX_HOUR    = 23;
    localparam int MAX_MIN     = 59;
    localparam int SEC_PER_MIN = 60;

    // Every digit must be a legal BCD value, not just the combined number.
    function automatic logic hhmm_valid(input hhmm_t t);
        int h;
        int m;
        h = 10 * int'(t.hour1) + int'(t.hour0);
        m = 10 * int'(t.min1) + int'(t.min0);
        return (t.hour0 <= 4'd9) && (h <= MAX_HOUR) &&
               (t.min1 <= 4'd5) && (t.min0 <= 4'd9) && (m <= MAX_MIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_time_counter.sv
//======================================================================
// Module      : bcd_time_counter
// Description : Seconds divider, BCD HH:MM:SS ripple and validated
//               time load. Flags the tick that rolls seconds to 00.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  ld_time_i,
    input  hhmm_t ld_hhmm_i,
    output logic  tick_1s_o,
    output logic  time_wrap_sec0_o,
    output hhmm_t hhmm_o,
    output hhmm_t nxt_hhmm_o,
    output bcd_t  sec1_o,
    output bcd_t  sec0_o
);

    localparam int            DW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICKS_PER_SEC - 1);

    logic [DW-1:0] div_q, div_d;
    hhmm_t         hhmm_q, hhmm_d;
    bcd_t          sec1_q, sec1_d, sec0_q, sec0_d;
    logic          w_ld_ok, w_tick, w_wrap;

    assign w_ld_ok = ld_time_i && hhmm_valid(ld_hhmm_i);
    assign w_tick  = (div_q == DIV_LAST);

    always_comb begin
        div_d  = w_tick ? '0 : div_q + DW'(1);
        hhmm_d = hhmm_q;
        sec1_d = sec1_q;
        sec0_d = sec0_q;
        w_wrap = 1'b0;
        // A load wins over a coincident tick and realigns the divider.
        if (w_ld_ok) begin
            hhmm_d = ld_hhmm_i;
            sec1_d = '0;
            sec0_d = '0;
            div_d  = '0;
        end else if (w_tick) begin
            if (sec0_q != 4'd9) begin
                sec0_d = sec0_q + 4'd1;
            end else begin
                sec0_d = '0;
                if (sec1_q != 4'd5) begin
                    sec1_d = sec1_q + 4'd1;
                end else begin
                    sec1_d = '0;
                    w_wrap = 1'b1;
                    if (hhmm_q.min0 != 4'd9) begin
                        hhmm_d.min0 = hhmm_q.min0 + 4'd1;
                    end else begin
                        hhmm_d.min0 = '0;
                        if (hhmm_q.min1 != 4'd5) begin
                            hhmm_d.min1 = hhmm_q.min1 + 4'd1;
                        end else begin
                            hhmm_d.min1 = '0;
                            if (hhmm_q.hour1 == 2'd2 && hhmm_q.hour0 == 4'd3) begin
                                hhmm_d.hour1 = '0;
                                hhmm_d.hour0 = '0;
                            end else if (hhmm_q.hour0 == 4'd9) begin
                                hhmm_d.hour0 = '0;
                                hhmm_d.hour1 = hhmm_q.hour1 + 2'd1;
                            end else begin
                                hhmm_d.hour0 = hhmm_q.hour0 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            hhmm_q <= '0;
            sec1_q <= '0;
            sec0_q <= '0;
        end else begin
            div_q  <= div_d;
            hhmm_q <= hhmm_d;
            sec1_q <= sec1_d;
            sec0_q <= sec0_d;
        end
    end

    assign tick_1s_o        = w_tick;
    assign time_wrap_sec0_o = w_wrap;
    assign hhmm_o           = hhmm_q;
    assign nxt_hhmm_o       = hhmm_d;
    assign sec1_o           = sec1_q;
    assign sec0_o           = sec0_q;

endmodule

`default_nettype wire

// File: rtl/multi_alarm_clock.sv
//======================================================================
// Module      : multi_alarm_clock
// Description : BCD clock with NUM_ALARMS alarm slots, snooze, ring
//               timeout and 12/24 h display.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int NUM_ALARMS    = 4,
    parameter int SNOOZE_MIN    = 5,
    parameter int RING_SEC      = 60,
    parameter int AW            = $clog2(NUM_ALARMS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    hour_in1,
    input  logic [3:0]    hour_in0,
    input  logic [3:0]    min_in1,
    input  logic [3:0]    min_in0,
    input  logic          LD_time,
    input  logic          LD_alarm,
    input  logic [AW-1:0] alarm_sel,
    input  logic          alarm_en_in,
    input  logic          AL_ON,
    input  logic          stop_al,
    input  logic          snooze,
    input  logic          mode_12h,
    output logic          Alarm,
    output logic [AW-1:0] alarm_id,
    output logic          snoozing,
    output logic          load_err,
    output logic          tick_1s,
    output logic          pm,
    output logic [1:0]    hour_out1,
    output logic [3:0]    hour_out0,
    output logic [3:0]    min_out1,
    output logic [3:0]    min_out0,
    output logic [3:0]    sec_out1,
    output logic [3:0]    sec_out0
);

    localparam int            SNZ_TICKS = SNOOZE_MIN * SEC_PER_MIN;
    localparam int            SW        = $clog2(SNZ_TICKS + 1);
    localparam int            RW        = $clog2(RING_SEC + 1);
    localparam logic [AW:0]   NUM_W     = (AW + 1)'(NUM_ALARMS);

    hhmm_t           w_ld, w_now, w_nxt;
    logic            w_tick, w_wrap, w_ld_valid, w_alarm_ok;
    logic [NUM_ALARMS-1:0] w_hit;
    logic            w_hit_any;
    logic [AW-1:0]   w_hit_id;
    alarm_slot_t     slots_q [NUM_ALARMS];
    state_t          state_q, state_d;
    logic [AW-1:0]   id_q, id_d;
    logic [RW-1:0]   ring_q, ring_d;
    logic [SW-1:0]   snz_q, snz_d;
    logic            load_err_q, load_err_d;
    logic [4:0]      w_hr_bin, w_hr12;

    assign w_ld       = {hour_in1, hour_in0, min_in1, min_in0};
    assign w_ld_valid = hhmm_valid(w_ld);
    assign w_alarm_ok = w_ld_valid && ({1'b0, alarm_sel} < NUM_W);
    assign load_err_d = (LD_time && !w_ld_valid) || (LD_alarm && !w_alarm_ok);

    bcd_time_counter #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_time (
        .clk              (clk),
        .reset            (reset),
        .ld_time_i        (LD_time),
        .ld_hhmm_i        (w_ld),
        .tick_1s_o        (w_tick),
        .time_wrap_sec0_o (w_wrap),
        .hhmm_o           (w_now),
        .nxt_hhmm_o       (w_nxt),
        .sec1_o           (sec_out1),
        .sec0_o           (sec_out0)
    );

    // Slots compare against the time being written on this edge, so the ring
    // lines up with the display showing HH:MM:00.
    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_slot
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                slots_q[k] <= '0;
            end else if (LD_alarm && w_alarm_ok && alarm_sel == AW'(k)) begin
                slots_q[k] <= {w_ld, alarm_en_in};
            end
        end
        assign w_hit[k] = w_wrap && AL_ON && slots_q[k].en &&
                          ({slots_q[k].hour1, slots_q[k].hour0,
                            slots_q[k].min1, slots_q[k].min0} == w_nxt);
    end

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_id  = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_hit_any = 1'b1;
                w_hit_id  = AW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (!AL_ON) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_hit_any && !stop_al) begin
                        state_d = RINGING;
                        id_d    = w_hit_id;
                        ring_d  = '0;
                    end
                end
                RINGING: begin
                    if (stop_al) begin
                        state_d = IDLE;
                    end else if (snooze) begin
                        state_d = SNOOZE;
                        snz_d   = SW'(SNZ_TICKS);
                    end else if (w_tick) begin
                        if (ring_q == RW'(RING_SEC - 1)) state_d = IDLE;
                        else                             ring_d  = ring_q + RW'(1);
                    end
                end
                SNOOZE: begin
                    if (stop_al) begin
                        state_d = IDLE;
                    end else if (w_hit_any) begin
                        state_d = RINGING;
                        id_d    = w_hit_id;
                        ring_d  = '0;
                    end else if (w_tick) begin
                        if (snz_q == SW'(1)) begin
                            state_d = RINGING;
                            ring_d  = '0;
                        end else begin
                            snz_d = snz_q - SW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= '0;
            ring_q     <= '0;
            snz_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            load_err_q <= load_err_d;
        end
    end

    assign Alarm    = (state_q == RINGING);
    assign snoozing = (state_q == SNOOZE);
    assign alarm_id = id_q;
    assign load_err = load_err_q;
    assign tick_1s  = w_tick;
    assign min_out1 = w_now.min1;
    assign min_out0 = w_now.min0;

    always_comb begin
        w_hr_bin  = {3'b000, w_now.hour1} * 5'd10 + {1'b0, w_now.hour0};
        w_hr12    = w_hr_bin;
        hour_out1 = w_now.hour1;
        hour_out0 = w_now.hour0;
        pm        = 1'b0;
        if (mode_12h) begin
            if (w_hr_bin == 5'd0)       w_hr12 = 5'd12;
            else if (w_hr_bin > 5'd12)  w_hr12 = w_hr_bin - 5'd12;
            pm = (w_hr_bin >= 5'd12);
            if (w_hr12 >= 5'd10) begin
                hour_out1 = 2'd1;
                hour_out0 = 4'(w_hr12 - 5'd10);
            end else begin
                hour_out1 = 2'd0;
                hour_out0 = w_hr12[3:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
//======================================================================
// Module      : tb_multi_alarm_clock
// Description : Directed self-checking bench for multi_alarm_clock.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_multi_alarm_clock;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] hour_in1;
    logic [3:0] hour_in0, min_in1, min_in0;
    logic       LD_time, LD_alarm, alarm_en_in, AL_ON, stop_al, snooze, mode_12h;
    logic [1:0] alarm_sel;
    logic       Alarm, snoozing, load_err, tick_1s, pm;
    logic [1:0] alarm_id;
    logic [1:0] hour_out1;
    logic [3:0] hour_out0, min_out1, min_out0, sec_out1, sec_out0;
    logic [21:0] disp;

    int checks = 0;
    int errors = 0;

    assign disp = {hour_out1, hour_out0, min_out1, min_out0, sec_out1, sec_out0};

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .TICKS_PER_SEC (2),
        .NUM_ALARMS    (3),
        .SNOOZE_MIN    (1),
        .RING_SEC      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hour_in1    (hour_in1),
        .hour_in0    (hour_in0),
        .min_in1     (min_in1),
        .min_in0     (min_in0),
        .LD_time     (LD_time),
        .LD_alarm    (LD_alarm),
        .alarm_sel   (alarm_sel),
        .alarm_en_in (alarm_en_in),
        .AL_ON       (AL_ON),
        .stop_al     (stop_al),
        .snooze      (snooze),
        .mode_12h    (mode_12h),
        .Alarm       (Alarm),
        .alarm_id    (alarm_id),
        .snoozing    (snoozing),
        .load_err    (load_err),
        .tick_1s     (tick_1s),
        .pm          (pm),
        .hour_out1   (hour_out1),
        .hour_out0   (hour_out0),
        .min_out1    (min_out1),
        .min_out0    (min_out0),
        .sec_out1    (sec_out1),
        .sec_out0    (sec_out0)
    );

    task automatic load_time(input logic [1:0] h1, input logic [3:0] h0,
                             input logic [3:0] m1, input logic [3:0] m0);
        @(negedge clk);
        hour_in1 = h1; hour_in0 = h0; min_in1 = m1; min_in0 = m0;
        LD_time = 1'b1;
        @(negedge clk);
        LD_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] sel, input logic [1:0] h1,
                              input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0, input logic en);
        @(negedge clk);
        hour_in1 = h1; hour_in0 = h0; min_in1 = m1; min_in0 = m0;
        alarm_sel = sel; alarm_en_in = en;
        LD_alarm = 1'b1;
        @(negedge clk);
        LD_alarm = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (disp !== 22'd0) begin
            errors++; $display("FAIL reset_digits: got %h expected %h", disp, 22'd0);
        end
        checks++;
        if ({Alarm, alarm_id, snoozing, load_err, tick_1s, pm} !== 7'd0) begin
            errors++; $display("FAIL reset_flags: got %b expected %b",
                               {Alarm, alarm_id, snoozing, load_err, tick_1s, pm}, 7'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tick_1s !== 1'b1) begin
            errors++; $display("FAIL first_tick: got %b expected 1", tick_1s);
        end
    endtask

    task automatic test_load_run;
        int n;
        load_time(2'd1, 4'd0, 4'd1, 4'd9);
        checks++;
        if (disp !== {2'd1, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0}) begin
            errors++; $display("FAIL load_1019: got %h expected %h", disp,
                               {2'd1, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0});
        end
        n = 0;
        repeat (120) begin
            @(negedge clk);
            if (tick_1s === 1'b1) n++;
        end
        checks++;
        if (n != 60) begin
            errors++; $display("FAIL tick_count: got %0d expected 60", n);
        end
        checks++;
        if (disp !== {2'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0}) begin
            errors++; $display("FAIL run_1020: got %h expected %h", disp,
                               {2'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0});
        end
    endtask

    task automatic test_wrap_12h;
        load_time(2'd2, 4'd3, 4'd5, 4'd9);
        repeat (120) @(negedge clk);
        checks++;
        if (disp !== 22'd0) begin
            errors++; $display("FAIL day_wrap: got %h expected %h", disp, 22'd0);
        end
        mode_12h = 1'b1;
        #1;
        checks++;
        if ({hour_out1, hour_out0, pm} !== {2'd1, 4'd2, 1'b0}) begin
            errors++; $display("FAIL h12_midnight: got %b expected %b",
                               {hour_out1, hour_out0, pm}, {2'd1, 4'd2, 1'b0});
        end
        load_time(2'd1, 4'd3, 4'd0, 4'd5);
        checks++;
        if ({disp, pm} !== {2'd0, 4'd1, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL h12_1305: got %h expected %h", {disp, pm},
                               {2'd0, 4'd1, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1});
        end
        mode_12h = 1'b0;
        #1;
        checks++;
        if ({hour_out1, hour_out0, pm} !== {2'd1, 4'd3, 1'b0}) begin
            errors++; $display("FAIL h24_1305: got %b expected %b",
                               {hour_out1, hour_out0, pm}, {2'd1, 4'd3, 1'b0});
        end
    endtask

    task automatic test_match;
        AL_ON = 1'b1;
        load_alarm(2'd2, 2'd1, 4'd0, 4'd2, 4'd0, 1'b1);
        load_alarm(2'd0, 2'd1, 4'd0, 4'd2, 4'd0, 1'b1);
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL valid_alarm_load: got %b expected 0", load_err);
        end
        load_time(2'd1, 4'd0, 4'd1, 4'd9);
        repeat (119) @(negedge clk);
        checks++;
        if ({Alarm, disp} !== {1'b0, 2'd1, 4'd0, 4'd1, 4'd9, 4'd5, 4'd9}) begin
            errors++; $display("FAIL pre_match: got %h expected %h", {Alarm, disp},
                               {1'b0, 2'd1, 4'd0, 4'd1, 4'd9, 4'd5, 4'd9});
        end
        @(negedge clk);
        checks++;
        if ({Alarm, alarm_id, disp} !== {1'b1, 2'd0, 2'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0}) begin
            errors++; $display("FAIL match_edge: got %h expected %h", {Alarm, alarm_id, disp},
                               {1'b1, 2'd0, 2'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0});
        end
        stop_al = 1'b1;
        @(negedge clk);
        stop_al = 1'b0;
        checks++;
        if (Alarm !== 1'b0) begin
            errors++; $display("FAIL stop_al: got %b expected 0", Alarm);
        end
    endtask

    task automatic test_snooze;
        int n;
        int cyc;
        load_time(2'd1, 4'd0, 4'd1, 4'd9);
        repeat (120) @(negedge clk);
        checks++;
        if (Alarm !== 1'b1) begin
            errors++; $display("FAIL snz_ring: got %b expected 1", Alarm);
        end
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        checks++;
        if ({snoozing, Alarm} !== 2'b10) begin
            errors++; $display("FAIL snz_enter: got %b expected 10", {snoozing, Alarm});
        end
        n = 0;
        cyc = 0;
        while (Alarm !== 1'b1 && cyc < 300) begin
            if (snoozing === 1'b1 && tick_1s === 1'b1) n++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({Alarm, alarm_id} !== {1'b1, 2'd0} || n != 60) begin
            errors++; $display("FAIL snz_resume: got alarm=%b id=%0d ticks=%0d expected alarm=1 id=0 ticks=60",
                               Alarm, alarm_id, n);
        end
        stop_al = 1'b1;
        snooze  = 1'b1;
        @(negedge clk);
        stop_al = 1'b0;
        snooze  = 1'b0;
        checks++;
        if ({Alarm, snoozing} !== 2'b00) begin
            errors++; $display("FAIL stop_and_snooze: got %b expected 00", {Alarm, snoozing});
        end
    endtask

    task automatic test_timeout;
        int n;
        int cyc;
        load_time(2'd1, 4'd0, 4'd1, 4'd9);
        repeat (120) @(negedge clk);
        n = 0;
        cyc = 0;
        while (Alarm === 1'b1 && cyc < 50) begin
            if (tick_1s === 1'b1) n++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (Alarm !== 1'b0 || n != 3 || cyc != 6) begin
            errors++; $display("FAIL ring_timeout: got alarm=%b ticks=%0d cycles=%0d expected alarm=0 ticks=3 cycles=6",
                               Alarm, n, cyc);
        end
        load_time(2'd1, 4'd0, 4'd1, 4'd9);
        repeat (120) @(negedge clk);
        checks++;
        if (Alarm !== 1'b1) begin
            errors++; $display("FAIL alon_ring: got %b expected 1", Alarm);
        end
        AL_ON = 1'b0;
        @(negedge clk);
        checks++;
        if (Alarm !== 1'b0) begin
            errors++; $display("FAIL alon_drop: got %b expected 0", Alarm);
        end
        AL_ON = 1'b1;
    endtask

    task automatic test_load_err;
        load_time(2'd0, 4'd8, 4'd3, 4'd0);
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL good_load_err: got %b expected 0", load_err);
        end
        load_time(2'd2, 4'd4, 4'd0, 4'd0);
        checks++;
        if ({load_err, hour_out1, hour_out0, min_out1, min_out0} !== {1'b1, 2'd0, 4'd8, 4'd3, 4'd0}) begin
            errors++; $display("FAIL reject_2400: got %h expected %h",
                               {load_err, hour_out1, hour_out0, min_out1, min_out0},
                               {1'b1, 2'd0, 4'd8, 4'd3, 4'd0});
        end
        @(negedge clk);
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got %b expected 0", load_err);
        end
        load_time(2'd1, 4'd2, 4'd6, 4'd0);
        checks++;
        if ({load_err, hour_out1, hour_out0, min_out1, min_out0} !== {1'b1, 2'd0, 4'd8, 4'd3, 4'd0}) begin
            errors++; $display("FAIL reject_1260: got %h expected %h",
                               {load_err, hour_out1, hour_out0, min_out1, min_out0},
                               {1'b1, 2'd0, 4'd8, 4'd3, 4'd0});
        end
        load_alarm(2'd3, 2'd1, 4'd0, 4'd2, 4'd0, 1'b1);
        checks++;
        if (load_err !== 1'b1) begin
            errors++; $display("FAIL reject_sel: got %b expected 1", load_err);
        end
        @(negedge clk);
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL sel_err_clear: got %b expected 0", load_err);
        end
    endtask

    task automatic test_reset_snooze;
        load_alarm(2'd0, 2'd1, 4'd0, 4'd2, 4'd0, 1'b0);
        load_time(2'd1, 4'd0, 4'd1, 4'd9);
        repeat (120) @(negedge clk);
        checks++;
        if ({Alarm, alarm_id} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL slot2_ring: got %b expected %b", {Alarm, alarm_id}, {1'b1, 2'd2});
        end
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (snoozing !== 1'b1) begin
            errors++; $display("FAIL rst_pre_snooze: got %b expected 1", snoozing);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({disp, Alarm, alarm_id, snoozing, load_err, tick_1s, pm} !== 29'd0) begin
            errors++; $display("FAIL reset_mid_snooze: got %h expected 0",
                               {disp, Alarm, alarm_id, snoozing, load_err, tick_1s, pm});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        hour_in1 = '0; hour_in0 = '0; min_in1 = '0; min_in0 = '0;
        LD_time = 1'b0; LD_alarm = 1'b0; alarm_sel = '0; alarm_en_in = 1'b0;
        AL_ON = 1'b0; stop_al = 1'b0; snooze = 1'b0; mode_12h = 1'b0;
        test_reset();
        test_load_run();
        test_wrap_12h();
        test_match();
        test_snooze();
        test_timeout();
        test_load_err();
        test_reset_snooze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
